// File: rtl/multicycle_mips_core.sv
// rtl/multicycle_mips_core.sv - multi-cycle MIPS-subset core with one shared memory port
// Each instruction walks FETCH/DECODE/EXEC/MEM/WB; memory accesses stall on mem_ready.
module multicycle_mips_core #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          ADDR_W   = 32,
   parameter int          CNT_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   output logic              halted,
   output logic [31:0]       pc_out,
   output logic [CNT_W-1:0]  instret
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t state, next_state;

   logic [31:0] pc, ir, a, b, alu_out, mdr;
   logic [31:0] rf [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] simm;

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign shamt = ir[10:6];
   assign funct = ir[5:0];
   assign simm  = {{16{ir[15]}}, ir[15:0]};

   logic is_r, is_lw, is_sw, is_beq, is_bne, is_j, legal, retire, taken;
   assign is_r   = (op == 6'h00);
   assign is_lw  = (op == 6'h23);
   assign is_sw  = (op == 6'h2B);
   assign is_beq = (op == 6'h04);
   assign is_bne = (op == 6'h05);
   assign is_j   = (op == 6'h02);
   assign taken  = (is_beq && (a == b)) || (is_bne && (a != b));

   always_comb begin
      legal = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: legal = 1'b1;
               default: legal = 1'b0;
            endcase
         end
         6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // Non-R opcodes reaching the ALU (addi, lw, sw) all need A + sext(imm).
   logic [31:0] alu_res;
   always_comb begin
      alu_res = a + simm;
      if (is_r) begin
         case (funct)
            6'h20:   alu_res = a + b;
            6'h22:   alu_res = a - b;
            6'h24:   alu_res = a & b;
            6'h25:   alu_res = a | b;
            6'h2A:   alu_res = {31'b0, $signed(a) < $signed(b)};
            6'h00:   alu_res = b << shamt;
            6'h02:   alu_res = b >> shamt;
            default: alu_res = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      retire     = 1'b0;
      case (state)
         S_FETCH:  if (mem_ready) next_state = S_DECODE;
         S_DECODE: next_state = legal ? S_EXEC : S_HALT;
         S_EXEC: begin
            if (is_beq || is_bne || is_j) begin
               next_state = S_FETCH;
               retire     = 1'b1;
            end else if (is_lw || is_sw) begin
               next_state = S_MEM;
            end else begin
               next_state = S_WB;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               next_state = is_sw ? S_FETCH : S_WB;
               retire     = is_sw;
            end
         end
         S_WB: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         default: next_state = S_HALT;
      endcase
   end

   logic [4:0]  wb_dest;
   logic [31:0] wb_val;
   assign wb_dest = is_r ? rd : rt;
   assign wb_val  = is_lw ? mdr : alu_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         ir      <= 32'h0;
         a       <= 32'h0;
         b       <= 32'h0;
         alu_out <= 32'h0;
         mdr     <= 32'h0;
         instret <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir <= mem_rdata;
                  pc <= pc + 32'd4;
               end
            end
            S_DECODE: begin
               a       <= rf[rs];
               b       <= rf[rt];
               alu_out <= pc + (simm << 2);
            end
            S_EXEC: begin
               if (is_beq || is_bne) begin
                  if (taken) pc <= alu_out;
               end else if (is_j) begin
                  pc <= {pc[31:28], ir[25:0], 2'b00};
               end else begin
                  alu_out <= alu_res;
               end
            end
            S_MEM: if (mem_ready && is_lw) mdr <= mem_rdata;
            S_WB:  if (wb_dest != 5'd0) rf[wb_dest] <= wb_val;
            default: ;
         endcase
         if (retire) instret <= instret + CNT_W'(1);
      end
   end

   // Memory outputs are decoded from state so they stay put across stall cycles.
   logic in_mem;
   assign in_mem    = !reset && (state == S_MEM);
   assign mem_req   = !reset && ((state == S_FETCH) || (state == S_MEM));
   assign mem_we    = in_mem && is_sw;
   assign mem_wdata = (in_mem && is_sw) ? b : 32'h0;
   assign halted    = (state == S_HALT);
   assign pc_out    = pc;

   always_comb begin
      mem_addr = '0;
      if (!reset) begin
         if (state == S_FETCH)    mem_addr = pc[ADDR_W-1:0];
         else if (state == S_MEM) mem_addr = alu_out[ADDR_W-1:0];
      end
   end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// tb/tb_multicycle_mips_core.sv - directed bench for multicycle_mips_core
module tb_multicycle_mips_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reset2 = 1'b1;
   logic        mem_req, mem_we, mem_ready, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instret;
   logic        mem_req2, mem_we2, halted2;
   logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc_out2;
   logic [1:0]  instret2;

   logic [31:0] mem [256];
   int          delay = 0;
   int          wcnt = 0;
   int          checks = 0;
   int          errors = 0;

   localparam logic [31:0] ILL = 32'hFC00_0000;

   always #5 clk = ~clk;

   multicycle_mips_core dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .halted(halted), .pc_out(pc_out), .instret(instret)
   );

   multicycle_mips_core #(.RESET_PC(32'h100), .ADDR_W(32), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset2), .mem_req(mem_req2), .mem_we(mem_we2),
      .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ready(1'b1),
      .mem_rdata(mem_rdata2), .halted(halted2), .pc_out(pc_out2), .instret(instret2)
   );

   assign mem_ready  = (wcnt >= delay);
   assign mem_rdata  = mem[mem_addr[9:2]];
   assign mem_rdata2 = mem[mem_addr2[9:2]];

   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_ready) begin
            wcnt <= 0;
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt <= 0;
      end
   end

   function automatic logic [31:0] ri(input int op, input int rs, input int rt, input int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] rr(input int rs, input int rt, input int rd, input int sh, input int fn);
      return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 64; i++) mem[i] = ILL;
   endtask

   task automatic restart();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic wait_halt(input string tag);
      int k = 0;
      while (!halted && k < 400) begin
         step();
         k++;
      end
      check(tag, {31'b0, halted}, 32'd1);
   endtask

   task automatic wait_store(input string tag);
      int k = 0;
      while (!(mem_req && mem_we) && k < 100) begin
         step();
         k++;
      end
      check(tag, {31'b0, mem_req && mem_we}, 32'd1);
   endtask

   initial begin
      clear_prog();
      for (int i = 64; i < 256; i++) mem[i] = ILL;
      for (int i = 0; i < 5; i++) mem[64 + i] = ri(8, 1, 1, 1);

      // Reset state
      clear_prog();
      mem[0] = ri(8, 0, 1, 5);
      mem[1] = ri(8, 0, 2, -3);
      mem[2] = rr(1, 2, 3, 0, 'h20);
      mem[3] = ri('h2B, 0, 3, 'h80);
      step(2);
      check("rst_pc", pc_out, 32'h0);
      check("rst_req", {31'b0, mem_req}, 32'd0);
      check("rst_we", {31'b0, mem_we}, 32'd0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_instret", instret, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      reset = 1'b0;

      // Test 1: three ALU ops in 12 cycles, then store R3 and halt
      step(12);
      check("t1_instret12", instret, 32'd3);
      check("t1_pc12", pc_out, 32'd12);
      step(4);
      check("t1_sw_instret", instret, 32'd4);
      check("t1_r3", mem[32], 32'd2);
      step();
      check("t1_not_yet_halt", {31'b0, halted}, 32'd0);
      step();
      check("t5_halted", {31'b0, halted}, 32'd1);
      check("t5_req", {31'b0, mem_req}, 32'd0);
      check("t5_instret", instret, 32'd4);
      step(3);
      check("t5_pc_frozen", pc_out, 32'd20);
      check("t5_req_later", {31'b0, mem_req}, 32'd0);
      check("t5_instret_later", instret, 32'd4);

      // Test 2: sw/lw with two wait cycles per access
      clear_prog();
      mem[0]  = {6'h02, 26'h10};
      mem[16] = ri(8, 0, 3, 2);
      mem[17] = ri('h2B, 0, 3, 8);
      mem[18] = ri('h23, 0, 4, 8);
      mem[19] = ri('h2B, 0, 4, 12);
      delay = 2;
      restart();
      wait_store("t2_store_seen");
      for (int i = 0; i < 3; i++) begin
         check("t2_hold_req", {31'b0, mem_req}, 32'd1);
         check("t2_hold_we", {31'b0, mem_we}, 32'd1);
         check("t2_hold_addr", mem_addr, 32'd8);
         check("t2_hold_wdata", mem_wdata, 32'd2);
         if (i < 2) check("t2_wait_ready", {31'b0, mem_ready}, 32'd0);
         step();
      end
      wait_halt("t2_halt");
      check("t2_mem8", mem[2], 32'd2);
      check("t2_r4", mem[3], 32'd2);
      check("t2_instret", instret, 32'd5);
      delay = 0;

      // Test 3: beq taken, bne not taken, jump; 3 cycles each
      clear_prog();
      mem[0]  = ri(8, 0, 1, 1);
      mem[1]  = ri(4, 1, 1, 4);
      mem[6]  = ri(5, 1, 1, 5);
      mem[7]  = {6'h02, 26'h10};
      mem[16] = ri('h2B, 0, 1, 'h80);
      restart();
      step(4);
      check("t3_addi_pc", pc_out, 32'd4);
      step();
      check("t3_beq_fetch_pc", pc_out, 32'd8);
      step(2);
      check("t3_beq_pc", pc_out, 32'd24);
      check("t3_beq_instret", instret, 32'd2);
      step(3);
      check("t3_bne_pc", pc_out, 32'd28);
      check("t3_bne_instret", instret, 32'd3);
      step(3);
      check("t3_j_pc", pc_out, 32'h40);
      check("t3_j_instret", instret, 32'd4);
      step(4);
      check("t3_sw_instret", instret, 32'd5);
      check("t3_sw_data", mem[32], 32'd1);

      // Test 4: $0 writes dropped, slt signed, shifts, sub
      clear_prog();
      mem[0]  = ri(8, 0, 0, 7);
      mem[1]  = rr(0, 0, 5, 0, 'h20);
      mem[2]  = ri(8, 0, 6, -1);
      mem[3]  = ri(8, 0, 7, 1);
      mem[4]  = rr(6, 7, 8, 0, 'h2A);
      mem[5]  = rr(0, 7, 9, 4, 'h00);
      mem[6]  = rr(0, 9, 10, 2, 'h02);
      mem[7]  = rr(7, 6, 11, 0, 'h22);
      mem[8]  = ri('h2B, 0, 5, 'h80);
      mem[9]  = ri('h2B, 0, 8, 'h84);
      mem[10] = ri('h2B, 0, 9, 'h88);
      mem[11] = ri('h2B, 0, 10, 'h8C);
      mem[12] = ri('h2B, 0, 11, 'h90);
      mem[13] = ri('h2B, 0, 0, 'h94);
      restart();
      wait_halt("t4_halt");
      check("t4_r5_zero", mem[32], 32'd0);
      check("t4_slt", mem[33], 32'd1);
      check("t4_sll", mem[34], 32'd16);
      check("t4_srl", mem[35], 32'd4);
      check("t4_sub", mem[36], 32'd2);
      check("t4_r0", mem[37], 32'd0);
      check("t4_instret", instret, 32'd14);

      // Test 6: reset lands during a stalled store
      clear_prog();
      mem[0] = ri(8, 0, 1, 3);
      mem[1] = ri('h2B, 0, 1, 'h80);
      delay = 5;
      restart();
      wait_store("t6_store_seen");
      step();
      check("t6_stalled", {31'b0, mem_ready}, 32'd0);
      check("t6_pre_instret", instret, 32'd1);
      reset = 1'b1;
      step();
      check("t6_pc", pc_out, 32'h0);
      check("t6_req", {31'b0, mem_req}, 32'd0);
      check("t6_we", {31'b0, mem_we}, 32'd0);
      check("t6_instret", instret, 32'd0);
      check("t6_no_store", mem[32], ILL);
      delay = 0;

      // CNT_W=2 instance at RESET_PC 0x100: five retires wrap to 1
      check("t6b_rst_pc", pc_out2, 32'h100);
      check("t6b_rst_instret", {30'b0, instret2}, 32'd0);
      reset2 = 1'b0;
      begin
         int k = 0;
         while (!halted2 && k < 100) begin
            step();
            k++;
         end
      end
      check("t6b_halt", {31'b0, halted2}, 32'd1);
      check("t6b_instret_wrap", {30'b0, instret2}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
